// File: rtl/risc_prog_loader_if.sv
// Stream, memory write port and core control bundle for risc_prog_loader.
// With RISC_PROG_LOADER_VERIFY_EN defined, the memory read-back signals are added.
interface risc_prog_loader_if #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
);
   logic              in_valid;
   logic [DWIDTH-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_wr;
   logic [AWIDTH-1:0] mem_addr;
   logic [DWIDTH-1:0] mem_data;
   logic              cpu_rst;
   logic              halt;
`ifdef RISC_PROG_LOADER_VERIFY_EN
   logic              mem_rd;
   logic [DWIDTH-1:0] mem_q;

   // master: the loader, driving memory and core; slave: stream source, memory and core
   modport master (
      input  in_valid, in_data, in_last, halt, mem_q,
      output in_ready, mem_wr, mem_addr, mem_data, cpu_rst, mem_rd
   );
   modport slave (
      output in_valid, in_data, in_last, halt, mem_q,
      input  in_ready, mem_wr, mem_addr, mem_data, cpu_rst, mem_rd
   );
`else
   // master: the loader, driving memory and core; slave: stream source, memory and core
   modport master (
      input  in_valid, in_data, in_last, halt,
      output in_ready, mem_wr, mem_addr, mem_data, cpu_rst
   );
   modport slave (
      output in_valid, in_data, in_last, halt,
      input  in_ready, mem_wr, mem_addr, mem_data, cpu_rst
   );
`endif
endinterface

// File: rtl/risc_prog_loader.sv
// Program loader and run supervisor for the risc core: streams bytes into memory, runs, times out.
// Optional read-back check of the loaded image enabled by RISC_PROG_LOADER_VERIFY_EN.
//
// state   | meaning
// IDLE    | waiting for start, core held in reset
// LOAD    | accepting stream bytes and writing them to memory
// VERIFY  | reading back the image and comparing its XOR (verify build only)
// RELEASE | one cycle for the final write to land, core still in reset
// RUN     | core running, counting clocks until halt or timeout
// DONE    | result held until the next start
module risc_prog_loader #(
   parameter int AWIDTH  = 5,
   parameter int DWIDTH  = 8,
   parameter int DEPTH   = 32,
   parameter int TIMEOUT = 1024,
   parameter int CNTW    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   risc_prog_loader_if.master  bus,
   output logic                busy,
   output logic                done,
   output logic                err_overflow,
   output logic                err_timeout,
`ifdef RISC_PROG_LOADER_VERIFY_EN
   output logic                err_verify,
`endif
   output logic [CNTW-1:0]     run_cycles
);

   localparam int CW = AWIDTH + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

`ifdef RISC_PROG_LOADER_VERIFY_EN
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VERIFY, S_RELEASE, S_RUN, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE} state_t;
`endif

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_wr_q, mem_wr_d;
   logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DWIDTH-1:0] mem_data_q, mem_data_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_overflow_q, err_overflow_d;
   logic              err_timeout_q, err_timeout_d;
   logic [CNTW-1:0]   run_cycles_q, run_cycles_d;
   logic [TW-1:0]     tmr_q, tmr_d;
`ifdef RISC_PROG_LOADER_VERIFY_EN
   logic              mem_rd_q, mem_rd_d;
   logic              q_vld_q, q_vld_d;
   logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [DWIDTH-1:0] xor_wr_q, xor_wr_d;
   logic [DWIDTH-1:0] xor_rd_q, xor_rd_d;
   logic              err_verify_q, err_verify_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         in_ready_q     <= 1'b0;
         mem_wr_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_data_q     <= '0;
         cpu_rst_q      <= 1'b1;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         err_overflow_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         run_cycles_q   <= '0;
         tmr_q          <= '0;
`ifdef RISC_PROG_LOADER_VERIFY_EN
         mem_rd_q       <= 1'b0;
         q_vld_q        <= 1'b0;
         rd_ptr_q       <= '0;
         xor_wr_q       <= '0;
         xor_rd_q       <= '0;
         err_verify_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         in_ready_q     <= in_ready_d;
         mem_wr_q       <= mem_wr_d;
         mem_addr_q     <= mem_addr_d;
         mem_data_q     <= mem_data_d;
         cpu_rst_q      <= cpu_rst_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         err_overflow_q <= err_overflow_d;
         err_timeout_q  <= err_timeout_d;
         run_cycles_q   <= run_cycles_d;
         tmr_q          <= tmr_d;
`ifdef RISC_PROG_LOADER_VERIFY_EN
         mem_rd_q       <= mem_rd_d;
         q_vld_q        <= q_vld_d;
         rd_ptr_q       <= rd_ptr_d;
         xor_wr_q       <= xor_wr_d;
         xor_rd_q       <= xor_rd_d;
         err_verify_q   <= err_verify_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      in_ready_d     = in_ready_q;
      mem_wr_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      mem_data_d     = mem_data_q;
      cpu_rst_d      = cpu_rst_q;
      busy_d         = busy_q;
      done_d         = done_q;
      err_overflow_d = err_overflow_q;
      err_timeout_d  = err_timeout_q;
      run_cycles_d   = run_cycles_q;
      tmr_d          = tmr_q;
`ifdef RISC_PROG_LOADER_VERIFY_EN
      mem_rd_d       = 1'b0;
      q_vld_d        = mem_rd_q;
      rd_ptr_d       = rd_ptr_q;
      xor_wr_d       = xor_wr_q;
      xor_rd_d       = xor_rd_q;
      err_verify_d   = err_verify_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d        = S_LOAD;
               cnt_d          = '0;
               run_cycles_d   = '0;
               done_d         = 1'b0;
               err_overflow_d = 1'b0;
               err_timeout_d  = 1'b0;
               in_ready_d     = 1'b1;
               busy_d         = 1'b1;
               cpu_rst_d      = 1'b1;
`ifdef RISC_PROG_LOADER_VERIFY_EN
               xor_wr_d       = '0;
               err_verify_d   = 1'b0;
`endif
            end
         end
         S_LOAD: begin
            if (bus.in_valid && in_ready_q) begin
               mem_wr_d   = 1'b1;
               mem_addr_d = cnt_q[AWIDTH-1:0];
               mem_data_d = bus.in_data;
               cnt_d      = cnt_q + CW'(1);
`ifdef RISC_PROG_LOADER_VERIFY_EN
               xor_wr_d   = xor_wr_q ^ bus.in_data;
`endif
               // the last memory word is always written, even when it overflows the stream
               if (bus.in_last || cnt_q == CW'(DEPTH - 1)) begin
                  in_ready_d     = 1'b0;
                  err_overflow_d = !bus.in_last;
`ifdef RISC_PROG_LOADER_VERIFY_EN
                  state_d        = S_VERIFY;
                  rd_ptr_d       = '0;
                  xor_rd_d       = '0;
`else
                  state_d        = S_RELEASE;
`endif
               end
            end
         end
`ifdef RISC_PROG_LOADER_VERIFY_EN
         S_VERIFY: begin
            // first cycle carries the final write, reads follow on the shared address bus
            if (q_vld_q) xor_rd_d = xor_rd_q ^ bus.mem_q;
            if (rd_ptr_q < cnt_q) begin
               mem_rd_d   = 1'b1;
               mem_addr_d = rd_ptr_q[AWIDTH-1:0];
               rd_ptr_d   = rd_ptr_q + CW'(1);
            end else begin
               state_d = S_RELEASE;
            end
         end
`endif
         S_RELEASE: begin
`ifdef RISC_PROG_LOADER_VERIFY_EN
            // the last read-back word arrives here
            if ((xor_rd_q ^ (q_vld_q ? bus.mem_q : '0)) != xor_wr_q) begin
               state_d      = S_DONE;
               err_verify_d = 1'b1;
               done_d       = 1'b1;
               busy_d       = 1'b0;
            end else begin
               state_d      = S_RUN;
               cpu_rst_d    = 1'b0;
               run_cycles_d = CNTW'(1);
               tmr_d        = TW'(TIMEOUT - 1);
            end
`else
            state_d      = S_RUN;
            cpu_rst_d    = 1'b0;
            run_cycles_d = CNTW'(1);
            tmr_d        = TW'(TIMEOUT - 1);
`endif
         end
         S_RUN: begin
            if (bus.halt) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (tmr_q == '0) begin
               state_d       = S_DONE;
               done_d        = 1'b1;
               busy_d        = 1'b0;
               err_timeout_d = 1'b1;
               cpu_rst_d     = 1'b1;
            end else begin
               tmr_d        = tmr_q - TW'(1);
               run_cycles_d = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + CNTW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_data  = mem_data_q;
   assign bus.cpu_rst   = cpu_rst_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_overflow  = err_overflow_q;
   assign err_timeout   = err_timeout_q;
   assign run_cycles    = run_cycles_q;
`ifdef RISC_PROG_LOADER_VERIFY_EN
   assign bus.mem_rd    = mem_rd_q;
   assign err_verify    = err_verify_q;
`endif

endmodule

// File: tb/tb_risc_prog_loader.sv
// Self-checking bench for risc_prog_loader: vector table, directed corner sequences, random loads.
// A core stub raises halt a chosen number of clocks after release.
module tb_risc_prog_loader;
   localparam int AW = 5, DW = 8, DEPTH = 32, TO = 100, CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy, done, err_overflow, err_timeout;
   logic [CW-1:0] run_cycles;

   risc_prog_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

   risc_prog_loader #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TO), .CNTW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus), .busy(busy), .done(done),
      .err_overflow(err_overflow), .err_timeout(err_timeout), .run_cycles(run_cycles)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // core stub: halt rises on RUN cycle halt_at (0 = never)
   int halt_at = 0;
   int stub_rc = 0;
   always @(posedge clk) begin
      if (bus.cpu_rst) stub_rc <= 0;
      else             stub_rc <= stub_rc + 1;
   end
   assign bus.halt = (halt_at != 0) && !bus.cpu_rst && (stub_rc >= halt_at - 1);

   int          wr_addr_q[$];
   logic [7:0]  wr_data_q[$];
   always @(negedge clk) begin
      if (bus.mem_wr) begin
         wr_addr_q.push_back(int'(bus.mem_addr));
         wr_data_q.push_back(bus.mem_data);
      end
   end

   typedef struct {
      int         n;
      int         last_idx;
      int         gap;
      int         halt_at;
      int         exp_writes;
      bit         exp_ovf;
      int         exp_rc;
      bit         exp_to;
      bit         exp_cpu_rst;
      logic [7:0] base;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pat(input logic [7:0] base, input int i);
      return base ^ 8'(i * 37);
   endfunction

   // reference outcome derived from the loading and run rules
   function automatic vec_t model(input int n, input int last_idx, input int gap, input int h,
                                  input logic [7:0] base);
      vec_t v;
      v.n = n; v.last_idx = last_idx; v.gap = gap; v.halt_at = h; v.base = base;
      if (last_idx >= 0 && last_idx < DEPTH) begin
         v.exp_writes = last_idx + 1; v.exp_ovf = 1'b0;
      end else begin
         v.exp_writes = DEPTH; v.exp_ovf = 1'b1;
      end
      if (h == 0 || h > TO) begin
         v.exp_rc = TO; v.exp_to = 1'b1; v.exp_cpu_rst = 1'b1;
      end else begin
         v.exp_rc = h; v.exp_to = 1'b0; v.exp_cpu_rst = 1'b0;
      end
      return v;
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic send(input int n, input int last_idx, input int gap, input logic [7:0] base,
                       output int acc, output int stalls);
      int tries;
      bit taken;
      int g;
      acc = 0; stalls = 0;
      for (int i = 0; i < n; i++) begin
         tries = 0; taken = 1'b0;
         bus.in_valid = 1'b1; bus.in_data = pat(base, i); bus.in_last = (i == last_idx);
         while (!taken && tries < 4) begin
            if (bus.in_ready) taken = 1'b1;
            else              stalls++;
            tries++;
            @(negedge clk);
         end
         bus.in_valid = 1'b0; bus.in_last = 1'b0;
         if (!taken) break;
         acc++;
         if (i == last_idx) break;
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         repeat (g) @(negedge clk);
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int w = 0;
      while (!done && w < TO + 60) begin
         @(negedge clk); w++;
      end
      chk({name, "_done"}, done, 1);
   endtask

   task automatic check_writes(input string name, input int exp_n, input logic [7:0] base);
      chk({name, "_nwrites"}, wr_addr_q.size(), exp_n);
      for (int k = 0; k < wr_addr_q.size() && k < exp_n; k++) begin
         chk({name, "_addr"}, wr_addr_q[k], k);
         chk({name, "_data"}, wr_data_q[k], pat(base, k));
      end
   endtask

   task automatic run_vec(input string name, input vec_t v);
      int acc, stalls;
      wr_addr_q.delete(); wr_data_q.delete();
      halt_at = v.halt_at;
      pulse_start();
      send(v.n, v.last_idx, v.gap, v.base, acc, stalls);
      wait_done(name);
      check_writes(name, v.exp_writes, v.base);
      chk({name, "_accepted"}, acc, v.exp_writes);
      chk({name, "_stalls"}, stalls, v.exp_ovf ? 4 : 0);
      chk({name, "_ovf"}, err_overflow, v.exp_ovf);
      chk({name, "_tmo"}, err_timeout, v.exp_to);
      chk({name, "_rc"}, run_cycles, v.exp_rc);
      chk({name, "_cpu_rst"}, bus.cpu_rst, v.exp_cpu_rst);
      chk({name, "_busy"}, busy, 0);
   endtask

   initial begin
      vec_t vecs[9];
      vec_t rv;
      int acc, stalls, n, li, h;

      vecs[0] = '{1,  0,  0, 3,   1,  1'b0, 3,   1'b0, 1'b0, 8'h00};
      vecs[1] = '{6,  5,  1, 14,  6,  1'b0, 14,  1'b0, 1'b0, 8'hA5};
      vecs[2] = '{33, -1, 0, 5,   32, 1'b1, 5,   1'b0, 1'b0, 8'h3C};
      vecs[3] = '{2,  1,  0, 0,   2,  1'b0, 100, 1'b1, 1'b1, 8'h11};
      vecs[4] = '{32, 31, 0, 7,   32, 1'b0, 7,   1'b0, 1'b0, 8'h5A};
      vecs[5] = '{3,  2,  2, 100, 3,  1'b0, 100, 1'b0, 1'b0, 8'h77};
      vecs[6] = '{4,  3,  0, 101, 4,  1'b0, 100, 1'b1, 1'b1, 8'h42};
      vecs[7] = '{5,  4,  0, 1,   5,  1'b0, 1,   1'b0, 1'b0, 8'hC3};
      vecs[8] = '{34, 32, 0, 9,   32, 1'b1, 9,   1'b0, 1'b0, 8'h96};

      rst = 1'b1; start = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_mem_wr", bus.mem_wr, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_data", bus.mem_data, 0);
      chk("rst_cpu_rst", bus.cpu_rst, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", err_overflow, 0);
      chk("rst_tmo", err_timeout, 0);
      chk("rst_rc", run_cycles, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // reset in the middle of a load, then a clean reload from address 0
      halt_at = 3;
      pulse_start();
      send(3, -1, 0, 8'h21, acc, stalls);
      chk("midrst_acc", acc, 3);
      #2 rst = 1'b1;
      #1;
      chk("midrst_mem_wr", bus.mem_wr, 0);
      chk("midrst_in_ready", bus.in_ready, 0);
      chk("midrst_cpu_rst", bus.cpu_rst, 1);
      chk("midrst_busy", busy, 0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      wr_addr_q.delete(); wr_data_q.delete();
      pulse_start();
      send(5, 4, 0, 8'h21, acc, stalls);
      wait_done("reload");
      check_writes("reload", 5, 8'h21);
      chk("reload_rc", run_cycles, 3);

      // start ignored while running, then a start in DONE clears the result
      wr_addr_q.delete(); wr_data_q.delete();
      halt_at = 11;
      pulse_start();
      send(33, -1, 0, 8'h6B, acc, stalls);
      chk("ign_in_run", bus.cpu_rst, 0);
      pulse_start();
      chk("ign_busy", busy, 1);
      chk("ign_done", done, 0);
      wait_done("ign");
      chk("ign_rc", run_cycles, 11);
      chk("ign_ovf", err_overflow, 1);
      chk("ign_tmo", err_timeout, 0);
      pulse_start();
      chk("rearm_done", done, 0);
      chk("rearm_ovf", err_overflow, 0);
      chk("rearm_rc", run_cycles, 0);
      chk("rearm_in_ready", bus.in_ready, 1);
      chk("rearm_cpu_rst", bus.cpu_rst, 1);
      halt_at = 3;
      send(1, 0, 0, 8'h00, acc, stalls);
      wait_done("rearm");
      chk("rearm_rc2", run_cycles, 3);

      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 3) == 0) begin
            n = 33 + int'($urandom_range(0, 1)); li = -1;
         end else begin
            n = int'($urandom_range(1, 34)); li = int'($urandom_range(0, n - 1));
         end
         h = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 110));
         rv = model(n, li, -1, h, 8'($urandom));
         run_vec($sformatf("rnd%0d", r), rv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/risc_prog_loader.md
Name: risc_prog_loader

Overview:
Hardware program loader and run supervisor for the `risc` core. It accepts a program as a byte stream over a valid/ready handshake and writes it sequentially into the core's 32x8 memory through the memory write port, holding the core in reset while it loads. It then releases the core, counts clocks until `halt` rises or a timeout expires, and reports the result. This is the writer/driver end of the core's memory-and-halt interface, so self-test programs can run on silicon without a simulator backdoor.

Parameters:
AWIDTH, 5, memory address width.
DWIDTH, 8, memory data and stream byte width.
DEPTH, 32, number of memory words; must equal 2**AWIDTH.
TIMEOUT, 1024, maximum RUN-state clocks before the run is aborted.
CNTW, 16, width of the `run_cycles` counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  single-cycle pulse that begins a load-and-run sequence.
in_valid  in  1  stream byte valid.
in_data  in  DWIDTH  stream byte: instruction {op[2:0], addr[4:0]} or data.
in_last  in  1  marks the final program byte.
in_ready  out  1  loader accepts a byte this cycle.
mem_wr  out  1  memory write strobe.
mem_addr  out  AWIDTH  memory write address.
mem_data  out  DWIDTH  memory write data.
cpu_rst  out  1  reset to the core, active-high.
halt  in  1  halt flag from the core.
busy  out  1  high in LOAD, RELEASE and RUN.
done  out  1  high in DONE until the next `start`.
err_overflow  out  1  stream exceeded DEPTH bytes.
err_timeout  out  1  TIMEOUT reached without `halt`.
run_cycles  out  CNTW  RUN clocks counted up to and including the one where `halt` is sampled high.

Behaviour:
- Reset (asynchronous, any state, including mid-load or mid-run):
  - State goes to IDLE.
  - `in_ready`, `mem_wr`, `busy`, `done`, `err_overflow` and `err_timeout` go to 0.
  - `mem_addr`, `mem_data` and `run_cycles` go to 0.
  - `cpu_rst` goes to 1.
- All outputs are registered. States are IDLE, LOAD, RELEASE, RUN and DONE.
- IDLE/DONE + `start` → LOAD:
  - Clear the write counter, `run_cycles`, `done` and both error flags.
  - `cpu_rst` stays 1.
  - `start` is ignored in LOAD, RELEASE and RUN.
- LOAD:
  - `in_ready` = 1, and is registered high from the first LOAD cycle.
  - A beat is accepted when `in_valid` & `in_ready`. On the next edge, `mem_wr` = 1, `mem_addr` = counter, `mem_data` = `in_data`, and the counter increments.
  - `mem_wr` is otherwise 0. Gaps in `in_valid` insert idle cycles.
- LOAD exit:
  - Accepted beat with `in_last` = 1 → RELEASE, and `in_ready` drops the same edge.
  - Accepted beat at counter = DEPTH-1 with `in_last` = 0: it is written to address DEPTH-1, `err_overflow` is set, and the state goes to RELEASE. Later stream bytes are never accepted in this sequence.
- Unwritten memory locations keep their prior contents.
- RELEASE: one cycle with `cpu_rst` = 1, letting the final write complete. Then → RUN.
- RUN:
  - `cpu_rst` = 0 from the first RUN cycle.
  - `run_cycles` increments every RUN cycle, starting at 1 on the first one, and saturates at 2**CNTW-1.
  - `halt` = 1 sampled → DONE. `run_cycles` holds its value, `cpu_rst` stays 0 (the core is frozen by its own halt), and `done` = 1.
  - `run_cycles` reaches TIMEOUT without `halt` → DONE with `err_timeout` = 1 and `cpu_rst` = 1.
  - `halt` and the timeout on the same cycle: `halt` wins and `err_timeout` = 0.
- DONE: outputs hold. `start` re-arms the sequence (→ LOAD).
- Core behaviour expected by software: HLT at address 0 raises `halt` on the 3rd clock after release. Every other instruction takes 8 clocks.

Optional Feature:
Macro: `RISC_PROG_LOADER_VERIFY_EN`.

Defined:
- Adds ports `mem_rd` (out, 1) and `mem_q` (in, DWIDTH, 1-cycle read latency), and a VERIFY state between LOAD and RELEASE.
- LOAD keeps a running XOR of accepted bytes.
- VERIFY reads back addresses 0..count-1 and XORs the returned data.
- On mismatch, `err_verify` (out, 1) is set and the state goes to DONE with `cpu_rst` = 1, so the core never runs.
- VERIFY adds count+1 clocks.

Undefined:
- No VERIFY state, no `mem_rd`, `mem_q` or `err_verify` ports.
- LOAD goes straight to RELEASE.

Test Plan:
- Single byte `8'h00` (HLT) with `in_last`; core stub raises `halt` 3 clocks after release.
  → One write at address 0 with data `8'h00`, then RELEASE and RUN; `run_cycles` = 3, `done` = 1, both errors 0.
- 6-byte JMP/SKZ/HLT program streamed with a 1-cycle `in_valid` gap after every byte.
  → Writes at addresses 0..5 in order with no dropped or duplicate beats; `in_ready` never drops until the last beat.
- 33 bytes streamed, `in_last` never set.
  → 32 writes (addresses 0..31), `err_overflow` = 1, 33rd byte not accepted, RUN entered.
- TIMEOUT = 100, `halt` held 0.
  → `run_cycles` = 100, `err_timeout` = 1, `cpu_rst` returns to 1, `done` = 1.
- `rst` pulsed after 3 of 5 bytes loaded.
  → Immediate return to IDLE, `mem_wr` = 0, `cpu_rst` = 1; a following `start` plus 5 bytes writes from address 0 again.
- `start` pulsed during RUN, then `halt` on RUN cycle 11.
  → `start` ignored; `run_cycles` = 11; a `start` in DONE clears the flags and re-enters LOAD.
